// File: rtl/noc_mmr_bank.sv
// noc_mmr_bank: memory-mapped register bank that launches load-NoC requests.
//
// Each channel occupies 8 words starting at BASE_ADDR + 32*ch:
//   words 0..ARG_REGS-1 : argument registers (R/W); the last one is the doorbell
//   word 6              : RESULT (RO)
//   word 7              : STATUS (RO; bit0 busy, bit1 done, bit2 err; read-to-clear err/done)
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   mmr_we/mmr_re/mmr_location/
//   mmr_wdata                          register access from writeback (we wins over re)
//   mmr_rdata/mmr_hit                  registered read data / in-bank flag of last access
//   noc_req_valid/ready/ch/data        request to the NoC, arg0 in the data LSBs
//   noc_rsp_valid/ch/data              response from the NoC

// Per-channel state: argument/result registers, error flag and the
// IDLE -> PEND -> WAIT -> DONE request lifecycle.
module noc_mmr_ch #(
  parameter int DATA_W   = 32,
  parameter int ARG_REGS = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,     // ARG write addressed here
  input  logic [2:0]                       wr_word,
  input  logic [DATA_W-1:0]                wr_data,
  input  logic                             st_rd,     // STATUS read addressed here
  input  logic                             grant,     // request handshake for this channel
  input  logic                             rsp_en,    // response addressed here
  input  logic [DATA_W-1:0]                rsp_data,
  output logic [ARG_REGS-1:0][DATA_W-1:0]  args,
  output logic [ARG_REGS-1:0][DATA_W-1:0]  args_nxt,  // args including this cycle's write
  output logic [DATA_W-1:0]                result,
  output logic [2:0]                       status,
  output logic                             pend,
  output logic                             db_acc     // doorbell accepted this cycle
);
  typedef enum logic [1:0] {IDLE, PEND, WAIT, DONE} state_t;

  state_t st, st_nxt;
  logic   err;
  logic   open;
  logic   wr_ok;

  // Arguments are only writable while no request is in flight.
  assign open   = (st == IDLE) || (st == DONE);
  assign wr_ok  = wr_en && open;
  assign db_acc = wr_ok && (wr_word == 3'(ARG_REGS - 1));
  assign pend   = (st == PEND);
  assign status = {err, st == DONE, (st == PEND) || (st == WAIT)};

  always_comb begin
    args_nxt = args;
    for (int k = 0; k < ARG_REGS; k++)
      if (wr_ok && wr_word == 3'(k)) args_nxt[k] = wr_data;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE: if (db_acc) st_nxt = PEND;
      PEND: if (grant) st_nxt = WAIT;
      WAIT: if (rsp_en) st_nxt = DONE;
      DONE: begin
        // Touching the channel (new args or a STATUS read) retires the result.
        if (db_acc)              st_nxt = PEND;
        else if (wr_ok || st_rd) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      err    <= 1'b0;
      args   <= '0;
      result <= '0;
    end else begin
      st   <= st_nxt;
      args <= args_nxt;
      if (rsp_en && st == WAIT) result <= rsp_data;
      // A new error event in the same cycle as the clearing read is kept.
      err <= (wr_en && !open) || (rsp_en && st != WAIT) || (err && !st_rd);
    end
  end
endmodule

module noc_mmr_bank #(
  parameter int          DATA_W    = 32,
  parameter int          NUM_CH    = 2,
  parameter int          ARG_REGS  = 4,
  parameter logic [31:0] BASE_ADDR = 32'h4000,
  localparam int         CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mmr_we,
  input  logic                       mmr_re,
  input  logic [31:0]                mmr_location,
  input  logic [DATA_W-1:0]          mmr_wdata,
  output logic [DATA_W-1:0]          mmr_rdata,
  output logic                       mmr_hit,
  output logic                       noc_req_valid,
  input  logic                       noc_req_ready,
  output logic [CH_W-1:0]            noc_req_ch,
  output logic [ARG_REGS*DATA_W-1:0] noc_req_data,
  input  logic                       noc_rsp_valid,
  input  logic [CH_W-1:0]            noc_rsp_ch,
  input  logic [DATA_W-1:0]          noc_rsp_data
);
  // Address decode; addresses below the base wrap to large offsets and miss.
  logic [31:0]     off;
  logic            in_rng;
  logic [CH_W-1:0] a_ch;
  logic [2:0]      a_word;

  assign off    = mmr_location - BASE_ADDR;
  assign in_rng = (off < 32'(NUM_CH * 32)) && (off[1:0] == 2'b00);
  assign a_ch   = off[5 +: CH_W];
  assign a_word = off[4:2];

  logic [ARG_REGS-1:0][DATA_W-1:0] ch_args [NUM_CH];
  logic [ARG_REGS-1:0][DATA_W-1:0] ch_nxt  [NUM_CH];
  logic [DATA_W-1:0]               ch_res  [NUM_CH];
  logic [2:0]                      ch_stat [NUM_CH];
  logic [NUM_CH-1:0]               pend;
  logic [NUM_CH-1:0]               db_acc;
  logic                            hs;

  assign hs = noc_req_valid && noc_req_ready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic sel_c;
    assign sel_c = in_rng && (a_ch == CH_W'(c));

    noc_mmr_ch #(.DATA_W(DATA_W), .ARG_REGS(ARG_REGS)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (mmr_we && sel_c && (a_word < 3'(ARG_REGS))),
      .wr_word  (a_word),
      .wr_data  (mmr_wdata),
      .st_rd    (mmr_re && !mmr_we && sel_c && (a_word == 3'd7)),
      .grant    (hs && (noc_req_ch == CH_W'(c))),
      .rsp_en   (noc_rsp_valid && (noc_rsp_ch == CH_W'(c))),
      .rsp_data (noc_rsp_data),
      .args     (ch_args[c]),
      .args_nxt (ch_nxt[c]),
      .result   (ch_res[c]),
      .status   (ch_stat[c]),
      .pend     (pend[c]),
      .db_acc   (db_acc[c])
    );
  end

  // Read mux
  logic [DATA_W-1:0] rd_val;

  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (a_ch == CH_W'(c)) begin
        for (int k = 0; k < ARG_REGS; k++)
          if (a_word == 3'(k)) rd_val = ch_args[c][k];
        if (a_word == 3'd6) rd_val = ch_res[c];
        if (a_word == 3'd7) rd_val = DATA_W'(ch_stat[c]);
      end
    end
  end

  // Round-robin arbiter. Eligible channels include a doorbell landing this
  // cycle (so valid rises the cycle after the doorbell) and exclude the channel
  // being accepted right now (so a new grant can follow back-to-back).
  logic [CH_W-1:0]                 ptr, ptr_hs, base, sel;
  logic                            found;
  logic [ARG_REGS-1:0][DATA_W-1:0] sel_data;

  always_comb begin
    ptr_hs   = (noc_req_ch == CH_W'(NUM_CH - 1)) ? '0 : noc_req_ch + 1'b1;
    base     = hs ? ptr_hs : ptr;
    found    = 1'b0;
    sel      = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!found && c == (int'(base) + i) % NUM_CH && (pend[c] || db_acc[c]) &&
            !(hs && noc_req_ch == CH_W'(c))) begin
          found    = 1'b1;
          sel      = CH_W'(c);
          sel_data = ch_nxt[c];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      noc_req_valid <= 1'b0;
      noc_req_ch    <= '0;
      noc_req_data  <= '0;
      ptr           <= '0;
      mmr_rdata     <= '0;
      mmr_hit       <= 1'b0;
    end else begin
      // Request payload is frozen while valid waits for ready.
      if (!noc_req_valid || noc_req_ready) begin
        noc_req_valid <= found;
        if (found) begin
          noc_req_ch   <= sel;
          noc_req_data <= sel_data;
        end
      end
      if (hs) ptr <= ptr_hs;
      if (mmr_we) begin
        mmr_hit <= in_rng;
      end else if (mmr_re) begin
        mmr_hit   <= in_rng;
        mmr_rdata <= in_rng ? rd_val : '0;
      end
    end
  end
endmodule

// File: tb/tb_noc_mmr_bank.sv
// tb_noc_mmr_bank: directed stimulus with a transaction-level model of the
// register bank checked every cycle, plus hand-computed literal expectations.
module tb_noc_mmr_bank;
  localparam int DATA_W   = 32;
  localparam int NUM_CH   = 2;
  localparam int ARG_REGS = 4;
  localparam int S_IDLE = 0, S_PEND = 1, S_WAIT = 2, S_DONE = 3;

  logic                       clk, rst_n;
  logic                       mmr_we, mmr_re;
  logic [31:0]                mmr_location;
  logic [DATA_W-1:0]          mmr_wdata, mmr_rdata;
  logic                       mmr_hit;
  logic                       noc_req_valid, noc_req_ready;
  logic [0:0]                 noc_req_ch;
  logic [ARG_REGS*DATA_W-1:0] noc_req_data;
  logic                       noc_rsp_valid;
  logic [0:0]                 noc_rsp_ch;
  logic [DATA_W-1:0]          noc_rsp_data;

  noc_mmr_bank #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .ARG_REGS(ARG_REGS), .BASE_ADDR(32'h4000)) dut (
    .clk(clk), .rst_n(rst_n),
    .mmr_we(mmr_we), .mmr_re(mmr_re), .mmr_location(mmr_location), .mmr_wdata(mmr_wdata),
    .mmr_rdata(mmr_rdata), .mmr_hit(mmr_hit),
    .noc_req_valid(noc_req_valid), .noc_req_ready(noc_req_ready),
    .noc_req_ch(noc_req_ch), .noc_req_data(noc_req_data),
    .noc_rsp_valid(noc_rsp_valid), .noc_rsp_ch(noc_rsp_ch), .noc_rsp_data(noc_rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- model ----------------
  logic [31:0]  m_arg [NUM_CH][ARG_REGS];
  logic [31:0]  m_res [NUM_CH];
  int           m_st  [NUM_CH];
  bit           m_err [NUM_CH];
  int           m_ptr, m_ch;
  bit           m_valid, m_hit;
  logic [127:0] m_data;
  logic [31:0]  m_rdata;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < ARG_REGS; k++) m_arg[c][k] = '0;
      m_res[c] = '0; m_st[c] = S_IDLE; m_err[c] = 1'b0;
    end
    m_ptr = 0; m_ch = 0; m_valid = 0; m_data = '0; m_rdata = '0; m_hit = 0;
  endtask

  function automatic logic [31:0] model_read(int ch, int w);
    if (w < ARG_REGS) return m_arg[ch][w];
    if (w == 6) return m_res[ch];
    if (w == 7) return 32'((m_st[ch] == S_PEND || m_st[ch] == S_WAIT) ? 1 : 0) |
                       32'((m_st[ch] == S_DONE) ? 2 : 0) | 32'(m_err[ch] ? 4 : 0);
    return '0;
  endfunction

  // One clock of the bank, computed from the pre-edge state and inputs.
  task automatic model_step();
    logic [31:0] off;
    bit inr, issue;
    int ch, w, rc;
    int st0[NUM_CH];
    off   = mmr_location - 32'h4000;
    inr   = (off < NUM_CH * 32) && (off % 4 == 0);
    ch    = inr ? int'(off / 32) : 0;
    w     = int'((off % 32) / 4);
    st0   = m_st;
    issue = !m_valid || noc_req_ready;
    if (mmr_we) m_hit = inr;
    else if (mmr_re) begin
      m_hit   = inr;
      m_rdata = inr ? model_read(ch, w) : '0;
      if (inr && w == 7) begin
        m_err[ch] = 0;
        if (st0[ch] == S_DONE) m_st[ch] = S_IDLE;
      end
    end
    if (m_valid && noc_req_ready) begin
      m_st[m_ch] = S_WAIT;
      m_ptr = (m_ch + 1) % NUM_CH;
    end
    rc = int'(noc_rsp_ch);
    if (noc_rsp_valid && rc < NUM_CH) begin
      if (st0[rc] == S_WAIT) begin m_res[rc] = noc_rsp_data; m_st[rc] = S_DONE; end
      else m_err[rc] = 1;
    end
    if (mmr_we && inr && w < ARG_REGS) begin
      if (st0[ch] == S_IDLE || st0[ch] == S_DONE) begin
        m_arg[ch][w] = mmr_wdata;
        m_st[ch] = (w == ARG_REGS - 1) ? S_PEND : S_IDLE;
      end else m_err[ch] = 1;
    end
    if (issue) begin
      m_valid = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        int c;
        c = (m_ptr + i) % NUM_CH;
        if (!m_valid && m_st[c] == S_PEND) begin
          m_valid = 1; m_ch = c;
          for (int k = 0; k < ARG_REGS; k++) m_data[k*32 +: 32] = m_arg[c][k];
        end
      end
    end
  endtask

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model advance and per-cycle comparison, 2 time units after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      model_step();
      #2;
      cmp("cyc_req_valid", 128'(noc_req_valid), 128'(m_valid));
      if (m_valid) begin
        cmp("cyc_req_ch", 128'(noc_req_ch), 128'(m_ch));
        cmp("cyc_req_data", 128'(noc_req_data), m_data);
      end
      cmp("cyc_hit", 128'(mmr_hit), 128'(m_hit));
      cmp("cyc_rdata", 128'(mmr_rdata), 128'(m_rdata));
    end
  end

  // ---------------- stimulus (called at a falling edge) ----------------
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mmr_we = 1; mmr_location = a; mmr_wdata = d;
    @(negedge clk);
    mmr_we = 0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v, output logic h);
    mmr_re = 1; mmr_location = a;
    @(negedge clk);
    mmr_re = 0; v = mmr_rdata; h = mmr_hit;
  endtask

  task automatic rsp(input logic [0:0] c, input logic [31:0] d);
    noc_rsp_valid = 1; noc_rsp_ch = c; noc_rsp_data = d;
    @(negedge clk);
    noc_rsp_valid = 0;
  endtask

  logic [31:0] v;
  logic        h;

  initial begin
    rst_n = 0; mmr_we = 0; mmr_re = 0; mmr_location = '0; mmr_wdata = '0;
    noc_req_ready = 0; noc_rsp_valid = 0; noc_rsp_ch = '0; noc_rsp_data = '0;
    repeat (2) @(negedge clk);
    cmp("rst_valid", 128'(noc_req_valid), 128'd0);
    cmp("rst_rdata", 128'(mmr_rdata), 128'd0);
    cmp("rst_hit", 128'(mmr_hit), 128'd0);
    rst_n = 1;
    @(negedge clk);

    // Basic launch on ch0
    noc_req_ready = 1;
    wr(32'h4000, 1); wr(32'h4004, 2); wr(32'h4008, 3);
    cmp("pre_db_valid", 128'(noc_req_valid), 128'd0);
    wr(32'h400C, 4);
    cmp("db_valid", 128'(noc_req_valid), 128'd1);
    cmp("db_ch", 128'(noc_req_ch), 128'd0);
    cmp("db_data", 128'(noc_req_data), 128'h00000004_00000003_00000002_00000001);
    rd(32'h401C, v, h); cmp("st_busy", 128'(v), 128'h1);

    // Response and read-to-clear
    rsp(0, 32'hDEADBEEF);
    rd(32'h4018, v, h); cmp("result", 128'(v), 128'hDEADBEEF);
    rd(32'h401C, v, h); cmp("st_done", 128'(v), 128'h2);
    rd(32'h401C, v, h); cmp("st_clr", 128'(v), 128'h0);

    // Write while in flight is dropped and flags err
    noc_req_ready = 0;
    wr(32'h400C, 5);
    noc_req_ready = 1; @(negedge clk); noc_req_ready = 0;
    wr(32'h4000, 32'h77);
    rd(32'h4000, v, h); cmp("arg0_kept", 128'(v), 128'h1);
    rd(32'h401C, v, h); cmp("st_err_busy", 128'(v), 128'h5);
    rsp(0, 32'h1234);
    rd(32'h401C, v, h); cmp("st_done2", 128'(v), 128'h2);

    // Arbitration: doorbell on ch1 lands in the same cycle ch0 is accepted
    wr(32'h400C, 6);
    cmp("rr1_valid", 128'(noc_req_valid), 128'd1);
    cmp("rr1_ch", 128'(noc_req_ch), 128'd0);
    noc_req_ready = 1;
    wr(32'h402C, 7);
    cmp("rr2_ch", 128'(noc_req_ch), 128'd1);
    cmp("rr2_data", 128'(noc_req_data), 128'h00000007_00000000_00000000_00000000);
    @(negedge clk);
    cmp("rr_drain", 128'(noc_req_valid), 128'd0);
    noc_req_ready = 0;
    rsp(1, 32'hB1); rsp(0, 32'hA0);
    // Second round, doorbells in reverse order
    wr(32'h402C, 8);
    cmp("rr3_ch", 128'(noc_req_ch), 128'd1);
    wr(32'h400C, 9);
    noc_req_ready = 1; @(negedge clk);
    cmp("rr4_ch", 128'(noc_req_ch), 128'd0);
    cmp("rr4_valid", 128'(noc_req_valid), 128'd1);
    @(negedge clk); noc_req_ready = 0;
    rsp(0, 32'hC0); rsp(1, 32'hC1);
    rd(32'h4018, v, h); cmp("res_ch0", 128'(v), 128'hC0);
    rd(32'h4038, v, h); cmp("res_ch1", 128'(v), 128'hC1);
    rd(32'h401C, v, h); rd(32'h403C, v, h);

    // Response and STATUS read in the same cycle
    noc_req_ready = 1;
    wr(32'h400C, 10);
    @(negedge clk); noc_req_ready = 0;
    noc_rsp_valid = 1; noc_rsp_ch = 0; noc_rsp_data = 32'hFACE;
    rd(32'h401C, v, h);
    noc_rsp_valid = 0;
    cmp("race_st", 128'(v), 128'h1);
    rd(32'h401C, v, h); cmp("race_done", 128'(v), 128'h2);

    // Stray response to an idle channel
    rsp(1, 32'h55);
    rd(32'h403C, v, h); cmp("stray_err", 128'(v), 128'h4);
    rd(32'h403C, v, h); cmp("stray_clr", 128'(v), 128'h0);

    // Out-of-range and unused words
    rd(32'h3FFC, v, h); cmp("low_rd", 128'(v), 128'h0); cmp("low_hit", 128'(h), 128'h0);
    rd(32'h4040, v, h); cmp("hi_rd", 128'(v), 128'h0); cmp("hi_hit", 128'(h), 128'h0);
    rd(32'h4002, v, h); cmp("mis_hit", 128'(h), 128'h0);
    wr(32'h4014, 32'hBAD);
    rd(32'h4014, v, h); cmp("w5_rd", 128'(v), 128'h0); cmp("w5_hit", 128'(h), 128'h1);
    wr(32'h4040, 32'h1234); cmp("oor_wr_hit", 128'(mmr_hit), 128'h0);

    // Asynchronous reset with a request stalled
    wr(32'h400C, 11);
    cmp("pre_rst_valid", 128'(noc_req_valid), 128'd1);
    #2 rst_n = 0;
    #1 cmp("async_valid", 128'(noc_req_valid), 128'd0);
    cmp("async_hit", 128'(mmr_hit), 128'd0);
    @(negedge clk); rst_n = 1;
    rd(32'h400C, v, h); cmp("post_arg3", 128'(v), 128'h0);
    rd(32'h4018, v, h); cmp("post_res", 128'(v), 128'h0);
    rd(32'h401C, v, h); cmp("post_st", 128'(v), 128'h0);
    rsp(0, 32'h99);
    rd(32'h401C, v, h); cmp("post_rsp_err", 128'(v), 128'h4);
    rd(32'h4018, v, h); cmp("post_rsp_res", 128'(v), 128'h0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/noc_mmr_bank.md
NOC_MMR_BANK -- requirements
Module: noc_mmr_bank

Interface
REQ-001 Parameter DATA_W, 32, register and data width.
REQ-002 Parameter NUM_CH, 2, load-NoC channels (1..8).
REQ-003 Parameter ARG_REGS, 4, argument registers per channel (1..6).
REQ-004 Parameter BASE_ADDR, 32'h4000, byte base of bank; channel stride 32 bytes (8 words).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 mmr_we / mmr_re  in  1 each  write / read strobe from writeback; both high = write only.
REQ-008 mmr_location  in  32  byte address.
REQ-009 mmr_wdata  in  DATA_W  write data.
REQ-010 mmr_rdata  out  DATA_W  registered read data.
REQ-011 mmr_hit  out  1  registered; address of last access fell inside bank.
REQ-012 noc_req_valid  out 1; noc_req_ready  in 1; noc_req_ch  out clog2(NUM_CH) (min 1); noc_req_data  out ARG_REGS*DATA_W, arg0 in LSBs.
REQ-013 noc_rsp_valid  in 1; noc_rsp_ch  in clog2(NUM_CH); noc_rsp_data  in DATA_W.

Function
REQ-014 Decode: off = mmr_location - BASE_ADDR; in range iff 0 <= off < NUM_CH*32 and off[1:0]==0; ch = off[31:5]; word = off[4:2].
REQ-015 Word 0..ARG_REGS-1 = ARG (R/W); word 6 = RESULT (RO); word 7 = STATUS (RO, bit0 busy, bit1 done, bit2 err, others 0); other words read 0, writes ignored.
REQ-016 Per-channel FSM states IDLE, PEND, WAIT, DONE.
REQ-017 ARG write in IDLE or DONE updates register; in DONE also moves to IDLE and clears done.
REQ-018 Write to word ARG_REGS-1 (doorbell) in IDLE/DONE stores data and moves to PEND next cycle.
REQ-019 Any ARG write in PEND or WAIT is dropped and sets err; state unchanged.
REQ-020 Arbiter: round-robin over PEND channels, pointer starts at ch0 after reset, advances to one past the granted channel on each accepted request.
REQ-021 noc_req_valid registered; once high, ch/data held stable until noc_req_valid&noc_req_ready; that cycle the channel goes PEND->WAIT.
REQ-022 noc_rsp_valid for a channel in WAIT: RESULT <= noc_rsp_data, state -> DONE, done=1, next cycle.
REQ-023 noc_rsp_valid for a channel not in WAIT or ch >= NUM_CH: ignored, sets err on that channel if ch < NUM_CH.
REQ-024 busy = state is PEND or WAIT.
REQ-025 Read: mmr_rdata/mmr_hit valid one cycle after mmr_re; out-of-range read gives rdata 0, hit 0; rdata holds when mmr_re low.
REQ-026 STATUS read is read-to-clear for err and done; done clear moves DONE->IDLE; rdata shows pre-clear value.
REQ-027 Same-cycle response and STATUS read of same channel: response wins, read returns pre-response status, done stays set.
REQ-028 Same-cycle doorbell write and grant of another channel: both take effect.
REQ-029 Out-of-range write: no state change, mmr_hit=0 next cycle.

Reset
REQ-030 rst_n low: all ARG/RESULT 0, all FSMs IDLE, err/done 0, arbiter pointer 0, noc_req_valid 0, mmr_rdata 0, mmr_hit 0, immediately, independent of clk.
REQ-031 Reset mid-handshake abandons outstanding request/response; responses arriving after release for IDLE channels set err only.

Verification
REQ-032 Write 0x4000..0x400C = 1,2,3,4, ready=1 -> noc_req_valid 1 cycle after doorbell, ch 0, data 0x00000004_00000003_00000002_00000001; ch0 STATUS=0x1.
REQ-033 Rsp ch0 data 0xDEADBEEF -> read 0x4018 = 0xDEADBEEF; read 0x401C = 0x2, second read = 0x0.
REQ-034 Doorbells ch0 and ch1 same window, ready=0 then 1 -> grants ch0 then ch1; repeat -> order follows pointer, no starvation.
REQ-035 Write 0x4000 while ch0 WAIT -> ARG0 unchanged, STATUS read = 0x5.
REQ-036 Read 0x3FFC and 0x4040 (NUM_CH=2) -> rdata 0, hit 0; write 0x4014 -> no effect.
REQ-037 Assert rst_n low with noc_req_valid high, ready low -> valid drops without clk edge; all reads 0 afterward.
